// File: rtl/pipe_ctrl.sv
// Pipeline control FSM: branch flush, halt/single-step debug and load-use stall.
// Outputs decode only from registered state, counters and the pc strobe/target registers.
module pipe_ctrl #(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned LU_STALL    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken_in,
  input  logic [23:0] branch_target_in,
  input  logic        halt_in,
  input  logic        resume_in,
  input  logic        step_in,
  input  logic        load_use_in,
  output logic        en_front_out,
  output logic        en_back_out,
  output logic        bubble_out,
  output logic        flush_out,
  output logic        pc_load_out,
  output logic [23:0] pc_target_out,
  output logic        halted_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);
  localparam logic [2:0] STALL_INIT = 3'(LU_STALL);

  state_t      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [2:0]  stall_cnt_q, stall_cnt_d;
  logic [23:0] pc_target_q, pc_target_d;
  logic        pc_load_q, pc_load_d;
  logic        stalling;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
      pc_target_q <= '0;
      pc_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      pc_target_q <= pc_target_d;
      pc_load_q   <= pc_load_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    pc_target_d = pc_target_q;
    pc_load_d   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (branch_taken_in) begin
          state_d     = S_FLUSH;
          flush_cnt_d = FLUSH_INIT;
          stall_cnt_d = '0;
          pc_target_d = branch_target_in;
          pc_load_d   = 1'b1;
        end else if (halt_in) begin
          state_d     = S_HALT;
          stall_cnt_d = '0;
        end else if (stall_cnt_q != '0) begin
          // an active stall is neither reloaded nor extended by a new hazard
          stall_cnt_d = stall_cnt_q - 3'd1;
        end else if (load_use_in) begin
          stall_cnt_d = STALL_INIT;
        end
      end
      S_FLUSH: begin
        flush_cnt_d = (flush_cnt_q == '0) ? '0 : flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) state_d = S_RUN;
      end
      S_HALT: begin
        if (resume_in)    state_d = S_RUN;
        else if (step_in) state_d = S_STEP;
      end
      S_STEP: begin
        if (branch_taken_in) begin
          state_d     = S_FLUSH;
          flush_cnt_d = FLUSH_INIT;
          stall_cnt_d = '0;
          pc_target_d = branch_target_in;
          pc_load_d   = 1'b1;
        end else begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign stalling      = (state_q == S_RUN) && (stall_cnt_q != '0);
  assign en_front_out  = (state_q != S_HALT) && !stalling;
  assign en_back_out   = (state_q != S_HALT);
  assign bubble_out    = (state_q == S_FLUSH) || stalling;
  assign flush_out     = (state_q == S_FLUSH);
  assign halted_out    = (state_q == S_HALT);
  assign state_out     = state_q;
  assign pc_load_out   = pc_load_q;
  assign pc_target_out = pc_target_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the control rules.
module tb_pipe_ctrl;

  localparam int FD = 2;
  localparam int LS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken_in, halt_in, resume_in, step_in, load_use_in;
  logic [23:0] branch_target_in;
  logic        en_front_out, en_back_out, bubble_out, flush_out, pc_load_out, halted_out;
  logic [23:0] pc_target_out;
  logic [1:0]  state_out;

  int n_checks = 0;
  int n_pass   = 0;

  // model: remaining flush cycles, remaining stall cycles, halted / stepping flags
  int          m_flush_left;
  int          m_stall_left;
  bit          m_halted;
  bit          m_step;
  bit          m_pc_load;
  logic [23:0] m_pc_target;

  pipe_ctrl #(.FLUSH_DEPTH(FD), .LU_STALL(LS)) dut (
    .clk              (clk),
    .rst              (rst),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .halt_in          (halt_in),
    .resume_in        (resume_in),
    .step_in          (step_in),
    .load_use_in      (load_use_in),
    .en_front_out     (en_front_out),
    .en_back_out      (en_back_out),
    .bubble_out       (bubble_out),
    .flush_out        (flush_out),
    .pc_load_out      (pc_load_out),
    .pc_target_out    (pc_target_out),
    .halted_out       (halted_out),
    .state_out        (state_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_stall_left = 0;
    m_halted     = 1'b0;
    m_step       = 1'b0;
    m_pc_load    = 1'b0;
    m_pc_target  = '0;
  endtask

  task automatic start_flush(input logic [23:0] tgt);
    m_flush_left = FD;
    m_stall_left = 0;
    m_halted     = 1'b0;
    m_pc_target  = tgt;
    m_pc_load    = 1'b1;
  endtask

  task automatic model_step(input bit br, input logic [23:0] tgt, input bit hl,
                            input bit rs, input bit st, input bit lu);
    m_pc_load = 1'b0;
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_step) begin
      m_step = 1'b0;
      if (br) start_flush(tgt);
      else    m_halted = 1'b1;
    end else if (m_halted) begin
      if (rs) m_halted = 1'b0;
      else if (st) begin
        m_halted = 1'b0;
        m_step   = 1'b1;
      end
    end else begin
      if (br) start_flush(tgt);
      else if (hl) begin
        m_stall_left = 0;
        m_halted     = 1'b1;
      end else if (m_stall_left > 0) m_stall_left--;
      else if (lu) m_stall_left = LS;
    end
  endtask

  task automatic check_all();
    bit          flushing, stalled;
    logic [1:0]  exp_state;
    flushing  = (m_flush_left > 0);
    stalled   = !flushing && !m_halted && !m_step && (m_stall_left > 0);
    exp_state = flushing ? 2'd1 : m_step ? 2'd3 : m_halted ? 2'd2 : 2'd0;
    check_eq("state",     32'(state_out),     32'(exp_state));
    check_eq("en_front",  32'(en_front_out),  32'(!m_halted && !stalled));
    check_eq("en_back",   32'(en_back_out),   32'(!m_halted));
    check_eq("bubble",    32'(bubble_out),    32'(flushing || stalled));
    check_eq("flush",     32'(flush_out),     32'(flushing));
    check_eq("pc_load",   32'(pc_load_out),   32'(m_pc_load));
    check_eq("pc_target", 32'(pc_target_out), 32'(m_pc_target));
    check_eq("halted",    32'(halted_out),    32'(m_halted));
  endtask

  task automatic cyc(input bit br, input logic [23:0] tgt, input bit hl,
                     input bit rs, input bit st, input bit lu);
    branch_taken_in  = br;
    branch_target_in = tgt;
    halt_in          = hl;
    resume_in        = rs;
    step_in          = st;
    load_use_in      = lu;
    @(posedge clk);
    model_step(br, tgt, hl, rs, st, lu);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 24'h0, 0, 0, 0, 0);
  endtask

  task automatic async_reset_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    branch_taken_in = 0; branch_target_in = '0; halt_in = 0;
    resume_in = 0; step_in = 0; load_use_in = 0;
    model_reset();
    #12;
    check_all();
    check_eq("rst_en_front", 32'(en_front_out), 32'd1);
    rst = 1'b0;

    // branch with flush of FD cycles
    cyc(1, 24'h000123, 0, 0, 0, 0);
    check_eq("br_pc_load", 32'(pc_load_out), 32'd1);
    check_eq("br_target",  32'(pc_target_out), 32'h000123);
    idle(3);
    check_eq("br_back_run", 32'(state_out), 32'd0);

    // halt, step, resume+step together
    cyc(0, 24'h0, 1, 0, 0, 0);
    idle(2);
    cyc(0, 24'h0, 0, 0, 1, 0);
    check_eq("step_en", 32'({en_front_out, en_back_out}), 32'd3);
    idle(2);
    check_eq("step_rehalt", 32'(halted_out), 32'd1);
    cyc(0, 24'h0, 0, 1, 1, 0);
    check_eq("resume_run", 32'(state_out), 32'd0);
    idle(1);

    // load-use held three cycles
    cyc(0, 24'h0, 0, 0, 0, 1);
    cyc(0, 24'h0, 0, 0, 0, 1);
    cyc(0, 24'h0, 0, 0, 0, 1);
    idle(2);

    // branch, halt and load-use together
    cyc(1, 24'h00ABCD, 1, 0, 0, 1);
    check_eq("simul_flush", 32'(state_out), 32'd1);
    idle(3);

    // reset during first flush cycle
    cyc(1, 24'h055555, 0, 0, 0, 0);
    async_reset_pulse();
    check_eq("rst_flush_off", 32'(flush_out), 32'd0);
    check_eq("rst_target_0",  32'(pc_target_out), 32'd0);
    idle(2);

    // branch inside the single-step cycle
    cyc(0, 24'h0, 1, 0, 0, 0);
    cyc(0, 24'h0, 0, 0, 1, 0);
    cyc(1, 24'hFFFFFF, 0, 0, 0, 0);
    check_eq("step_br_target", 32'(pc_target_out), 32'hFFFFFF);
    idle(3);
    check_eq("step_br_run", 32'(state_out), 32'd0);

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset_pulse();
      cyc($urandom_range(0, 9) == 0, 24'($urandom), $urandom_range(0, 11) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter FLUSH_DEPTH, default 2: cycles of younger-stage squash after a taken branch; legal range 1..7.
REQ-002 Parameter LU_STALL, default 1: front-end hold cycles per load-use hazard; legal range 1..3.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 branch_taken_in  input  1  latched EX-to-MA branch-taken flag.
REQ-006 branch_target_in  input  24  latched EX result: branch target address.
REQ-007 halt_in  input  1  HLT opcode present in EX with EX enabled.
REQ-008 resume_in  input  1  debug request: leave HALT.
REQ-009 step_in  input  1  debug request: execute one instruction from HALT.
REQ-010 load_use_in  input  1  decode reports source register equal to a load target in EX.
REQ-011 en_front_out  output  1  enable for the IF and ID latches.
REQ-012 en_back_out  output  1  enable for the EX, MA and WB latches.
REQ-013 bubble_out  output  1  forces a NOP into the EX input.
REQ-014 flush_out  output  1  invalidates IF/ID/EX contents this cycle.
REQ-015 pc_load_out  output  1  one-cycle strobe: PC takes pc_target_out.
REQ-016 pc_target_out  output  24  registered branch target.
REQ-017 halted_out  output  1  high while in HALT.
REQ-018 state_out  output  2  encoded state: RUN=0, FLUSH=1, HALT=2, STEP=3.

Function
REQ-019 The FSM SHALL have four states: RUN, FLUSH, HALT and STEP; all outputs SHALL be registered or decoded from registered state only.
REQ-020 Priority in RUN SHALL be branch_taken_in > halt_in > load_use_in.
REQ-021 RUN with branch_taken_in SHALL, next cycle, enter FLUSH, assert pc_load_out for exactly 1 cycle, latch pc_target_out = branch_target_in and load flush counter = FLUSH_DEPTH.
REQ-022 FLUSH SHALL assert flush_out and bubble_out every cycle, decrement the counter, and return to RUN on the cycle after the counter reaches 1 (flush_out high exactly FLUSH_DEPTH cycles).
REQ-023 In FLUSH, branch_taken_in, halt_in and load_use_in SHALL be ignored (they come from squashed instructions).
REQ-024 RUN with halt_in (no branch) SHALL enter HALT next cycle: en_front_out=0, en_back_out=0, halted_out=1.
REQ-025 HALT with resume_in SHALL return to RUN next cycle; resume_in SHALL win over a simultaneous step_in.
REQ-026 HALT with step_in alone SHALL enter STEP for exactly 1 cycle with en_front_out=en_back_out=1, then return to HALT, unless branch_taken_in is high during STEP, which SHALL enter FLUSH as in REQ-021.
REQ-027 RUN with load_use_in (no branch, no halt) SHALL load stall counter = LU_STALL and, for LU_STALL cycles, drive en_front_out=0, bubble_out=1, en_back_out=1; state remains RUN.
REQ-028 A load_use_in asserted while the stall counter is nonzero SHALL NOT reload or extend it.
REQ-029 A branch_taken_in or halt_in arriving during a load-use stall SHALL cancel the stall (counter cleared) and take its own transition.
REQ-030 Idle RUN outputs SHALL be en_front_out=1, en_back_out=1, bubble_out=0, flush_out=0, pc_load_out=0, halted_out=0.
REQ-031 pc_target_out SHALL hold its last value except on a branch capture.
REQ-032 Counters SHALL be 3 bits wide, saturate at 0 and never wrap.

Reset
REQ-033 rst high SHALL force, asynchronously, state=RUN, both counters=0, pc_target_out=0, pc_load_out=0, flush_out=0, bubble_out=0, halted_out=0, en_front_out=1, en_back_out=1.
REQ-034 rst asserted mid-FLUSH, mid-stall or in HALT SHALL abandon that operation, with no residual strobe after release.
REQ-035 The first rising edge after rst deassertion SHALL evaluate inputs from RUN.

Verification
REQ-036 Branch: branch_taken_in=1, branch_target_in=0x000123 for 1 cycle -> pc_load_out 1 cycle, pc_target_out=0x000123, flush_out high 2 cycles, then RUN.
REQ-037 Halt/step/resume: halt_in -> halted_out=1, enables 0; step_in -> enables 1 for exactly 1 cycle, back to HALT; resume_in+step_in together -> RUN.
REQ-038 Load-use: load_use_in high 3 consecutive cycles, LU_STALL=1 -> en_front_out low for exactly 1 cycle per non-overlapping hazard, bubble_out coincident, en_back_out stays 1.
REQ-039 Simultaneous: branch_taken_in, halt_in and load_use_in all high in one cycle -> FLUSH; halt ignored; no HALT entry.
REQ-040 Reset mid-FLUSH (cycle 1 of 2) -> immediate RUN idle outputs, flush_out=0, pc_target_out=0.
REQ-041 Branch during STEP: step_in, then branch_taken_in=1 with target 0xFFFFFF in the STEP cycle -> FLUSH, pc_target_out=0xFFFFFF, then RUN (not HALT).
